battleship_board_engine: RTL and testbench

BATTLESHIP_BOARD_ENGINE -- requirements
Module: battleship_board_engine

---
 rtl/battleship_board_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_battleship_board_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_board_engine.sv
// Two-player battleship board engine: placement, firing, scoring and a render read port.
// Define BATTLESHIP_FOG_EN to hide the opponent's unhit ships on the read port during FIRE.
module battleship_board_engine #(
   parameter int GRID_N     = 9,
   parameter int COORD_W    = 4,
   parameter int SHIP_CELLS = 12
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_op,
   input  logic [COORD_W-1:0]                cmd_row,
   input  logic [COORD_W-1:0]                cmd_col,
   output logic                              rsp_valid,
   output logic [2:0]                        rsp_code,
   output logic [1:0]                        phase,
   output logic                              active_player,
   output logic                              winner,
   output logic [$clog2(SHIP_CELLS+1)-1:0]   p1_remaining,
   output logic [$clog2(SHIP_CELLS+1)-1:0]   p2_remaining,
   input  logic                              rd_player,
   input  logic [COORD_W-1:0]                rd_row,
   input  logic [COORD_W-1:0]                rd_col,
   output logic [1:0]                        rd_data
);

   localparam int CELLS = GRID_N * GRID_N;
   localparam int IW    = $clog2(CELLS);
   localparam int LW    = 2 * COORD_W + 1;
   localparam int RW    = $clog2(SHIP_CELLS + 1);

   localparam logic [RW-1:0]      REM_MAX = RW'(SHIP_CELLS);
   localparam logic [COORD_W-1:0] LIM     = COORD_W'(GRID_N);

   localparam logic [1:0] C_EMPTY = 2'b00;
   localparam logic [1:0] C_SHIP  = 2'b01;
   localparam logic [1:0] C_MISS  = 2'b10;
   localparam logic [1:0] C_HIT   = 2'b11;

   localparam logic [2:0] R_PLACED = 3'd0;
   localparam logic [2:0] R_MISS   = 3'd1;
   localparam logic [2:0] R_HIT    = 3'd2;
   localparam logic [2:0] R_REPEAT = 3'd3;
   localparam logic [2:0] R_INV    = 3'd4;
   localparam logic [2:0] R_WIN    = 3'd5;

   typedef enum logic [1:0] {
      PH_P1   = 2'd0,
      PH_P2   = 2'd1,
      PH_FIRE = 2'd2,
      PH_OVER = 2'd3
   } phase_t;

   phase_t        r_phase;
   logic          r_act;
   logic          r_win;
   logic [RW-1:0] r_rem [2];
   logic [1:0]    r_grid [2][CELLS];
   logic          r_rsp_valid;
   logic [2:0]    r_rsp_code;
   logic [1:0]    r_rd;

   logic          w_acc;
   logic          w_cmd_in;
   logic [LW-1:0] w_cmd_lin;
   logic [IW-1:0] w_cmd_idx;
   logic          w_tgt;
   logic [1:0]    w_cell;
   logic          w_do_place;
   logic          w_do_fire;
   logic [RW-1:0] w_dec;

   phase_t        w_nxt_phase;
   logic          w_nxt_act;
   logic          w_nxt_win;
   logic [RW-1:0] w_nxt_rem [2];
   logic          w_wr_en;
   logic [1:0]    w_wr_val;
   logic [2:0]    w_rsp_code;

   logic          w_rd_in;
   logic [LW-1:0] w_rd_lin;
   logic [IW-1:0] w_rd_idx;
   logic [1:0]    w_rd_raw;
   logic          w_rd_fog;

   assign cmd_ready = (r_phase != PH_OVER);
   assign w_acc     = cmd_valid & cmd_ready;

   assign w_cmd_in  = (cmd_row < LIM) && (cmd_col < LIM);
   assign w_cmd_lin = LW'(cmd_row) * LW'(GRID_N) + LW'(cmd_col);
   assign w_cmd_idx = w_cmd_in ? IW'(w_cmd_lin) : '0;

   // Placement writes the actor's own board; shots land on the opponent's.
   assign w_tgt  = (r_phase == PH_FIRE) ? ~r_act : r_act;
   assign w_cell = r_grid[w_tgt][w_cmd_idx];
   assign w_dec  = (r_rem[w_tgt] == '0) ? '0 : r_rem[w_tgt] - 1'b1;

   assign w_do_place = w_acc & w_cmd_in & ~cmd_op &
                       ((r_phase == PH_P1) | (r_phase == PH_P2));
   assign w_do_fire  = w_acc & w_cmd_in & cmd_op & (r_phase == PH_FIRE);

   always_comb begin
      w_nxt_phase  = r_phase;
      w_nxt_act    = r_act;
      w_nxt_win    = r_win;
      w_nxt_rem[0] = r_rem[0];
      w_nxt_rem[1] = r_rem[1];
      w_wr_en      = 1'b0;
      w_wr_val     = C_EMPTY;
      w_rsp_code   = R_INV;
      unique case (1'b1)
         w_do_place: begin
            if (w_cell == C_EMPTY) begin
               w_wr_en    = 1'b1;
               w_wr_val   = C_SHIP;
               w_rsp_code = R_PLACED;
               if (r_rem[w_tgt] != REM_MAX)
                  w_nxt_rem[w_tgt] = r_rem[w_tgt] + 1'b1;
               if (r_rem[w_tgt] + 1'b1 >= REM_MAX) begin
                  w_nxt_phase = (r_phase == PH_P1) ? PH_P2 : PH_FIRE;
                  w_nxt_act   = (r_phase == PH_P1);
               end
            end else begin
               w_rsp_code = R_REPEAT;
            end
         end
         w_do_fire: begin
            case (w_cell)
               C_EMPTY: begin
                  w_wr_en    = 1'b1;
                  w_wr_val   = C_MISS;
                  w_rsp_code = R_MISS;
                  w_nxt_act  = ~r_act;
               end
               C_SHIP: begin
                  w_wr_en          = 1'b1;
                  w_wr_val         = C_HIT;
                  w_nxt_rem[w_tgt] = w_dec;
                  if (w_dec == '0) begin
                     w_rsp_code  = R_WIN;
                     w_nxt_phase = PH_OVER;
                     w_nxt_win   = r_act;
                  end else begin
                     w_rsp_code = R_HIT;
                     w_nxt_act  = ~r_act;
                  end
               end
               default: w_rsp_code = R_REPEAT;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase  <= PH_P1;
         r_act    <= 1'b0;
         r_win    <= 1'b0;
         r_rem[0] <= '0;
         r_rem[1] <= '0;
      end else begin
         r_phase  <= w_nxt_phase;
         r_act    <= w_nxt_act;
         r_win    <= w_nxt_win;
         r_rem[0] <= w_nxt_rem[0];
         r_rem[1] <= w_nxt_rem[1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < 2; p++)
            for (int i = 0; i < CELLS; i++)
               r_grid[p][i] <= C_EMPTY;
      end else if (w_wr_en) begin
         r_grid[w_tgt][w_cmd_idx] <= w_wr_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_code  <= 3'd0;
      end else begin
         r_rsp_valid <= w_acc;
         if (w_acc)
            r_rsp_code <= w_rsp_code;
      end
   end

   assign w_rd_in  = (rd_row < LIM) && (rd_col < LIM);
   assign w_rd_lin = LW'(rd_row) * LW'(GRID_N) + LW'(rd_col);
   assign w_rd_idx = w_rd_in ? IW'(w_rd_lin) : '0;
   assign w_rd_raw = r_grid[rd_player][w_rd_idx];

`ifdef BATTLESHIP_FOG_EN
   assign w_rd_fog = (r_phase == PH_FIRE) && (rd_player != r_act) &&
                     (w_rd_raw == C_SHIP);
`else
   assign w_rd_fog = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_rd <= C_EMPTY;
      else if (!w_rd_in || w_rd_fog)
         r_rd <= C_EMPTY;
      else
         r_rd <= w_rd_raw;
   end

   // A reset landing on the response cycle squashes that response.
   assign rsp_valid     = r_rsp_valid & ~reset;
   assign rsp_code      = r_rsp_code;
   assign phase         = r_phase;
   assign active_player = r_act;
   assign winner        = r_win;
   assign p1_remaining  = r_rem[0];
   assign p2_remaining  = r_rem[1];
   assign rd_data       = r_rd;

endmodule

// File: tb/tb_battleship_board_engine.sv
// Directed scoreboard bench for battleship_board_engine (GRID_N=9, SHIP_CELLS=3).
module tb_battleship_board_engine;

   localparam int GN = 9;
   localparam int CW = 4;
   localparam int SC = 3;
   localparam int RW = $clog2(SC + 1);

   localparam logic [2:0] PLACED = 3'd0;
   localparam logic [2:0] MISS   = 3'd1;
   localparam logic [2:0] HIT    = 3'd2;
   localparam logic [2:0] REPEAT = 3'd3;
   localparam logic [2:0] INV    = 3'd4;
   localparam logic [2:0] WIN    = 3'd5;
   localparam logic [2:0] NONE   = 3'd7;

`ifdef BATTLESHIP_FOG_EN
   localparam logic [1:0] FOGGED = 2'b00;
`else
   localparam logic [1:0] FOGGED = 2'b01;
`endif

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_op;
   logic [CW-1:0] cmd_row;
   logic [CW-1:0] cmd_col;
   logic          rsp_valid;
   logic [2:0]    rsp_code;
   logic [1:0]    phase;
   logic          active_player;
   logic          winner;
   logic [RW-1:0] p1_remaining;
   logic [RW-1:0] p2_remaining;
   logic          rd_player;
   logic [CW-1:0] rd_row;
   logic [CW-1:0] rd_col;
   logic [1:0]    rd_data;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] q[$];

   battleship_board_engine #(
      .GRID_N(GN),
      .COORD_W(CW),
      .SHIP_CELLS(SC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_row(cmd_row),
      .cmd_col(cmd_col),
      .rsp_valid(rsp_valid),
      .rsp_code(rsp_code),
      .phase(phase),
      .active_player(active_player),
      .winner(winner),
      .p1_remaining(p1_remaining),
      .p2_remaining(p2_remaining),
      .rd_player(rd_player),
      .rd_row(rd_row),
      .rd_col(rd_col),
      .rd_data(rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rsp();
      logic [2:0] e;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_code", 32'(rsp_code), 32'(e));
      end else begin
         chk("rsp_idle", 32'(rsp_valid), 32'd0);
      end
   endtask

   // Called at a negedge: checks last cycle's response, drives one cycle.
   task automatic cyc(input logic v, input logic op, input int r,
                      input int c, input logic [2:0] e);
      chk_rsp();
      cmd_valid = v;
      cmd_op    = op;
      cmd_row   = CW'(r);
      cmd_col   = CW'(c);
      if (v && e != NONE)
         q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic rd_set(input logic p, input int r, input int c);
      rd_player = p;
      rd_row    = CW'(r);
      rd_col    = CW'(c);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      cmd_valid = 1'b0;
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_row   = '0;
      cmd_col   = '0;
      rd_set(1'b0, 0, 0);
      do_reset();

      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_act", 32'(active_player), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_p1rem", 32'(p1_remaining), 32'd0);
      chk("rst_p2rem", 32'(p2_remaining), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_code", 32'(rsp_code), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rd", 32'(rd_data), 32'd0);

      // P1 placement, back-to-back
      cyc(1, 0, 0, 0, PLACED);
      cyc(1, 0, 0, 1, PLACED);
      cyc(1, 0, 0, 0, REPEAT);
      chk("p1rem_after_repeat", 32'(p1_remaining), 32'd2);
      cyc(1, 0, 0, 2, PLACED);
      chk("p1rem_full", 32'(p1_remaining), 32'd3);
      chk("phase_p2", 32'(phase), 32'd1);
      chk("act_p2", 32'(active_player), 32'd1);

      // invalid commands
      cyc(1, 0, 9, 3, INV);
      cyc(1, 1, 0, 0, INV);
      cyc(1, 0, 3, 12, INV);
      chk("inv_p1rem", 32'(p1_remaining), 32'd3);
      chk("inv_p2rem", 32'(p2_remaining), 32'd0);
      chk("inv_phase", 32'(phase), 32'd1);

      // P2 placement
      cyc(1, 0, 5, 5, PLACED);
      cyc(1, 0, 5, 6, PLACED);
      cyc(1, 0, 5, 7, PLACED);
      chk("phase_fire", 32'(phase), 32'd2);
      chk("act_fire", 32'(active_player), 32'd0);
      chk("p2rem_full", 32'(p2_remaining), 32'd3);
      cyc(1, 0, 1, 1, INV);

      // firing
      rd_set(1'b1, 5, 5);
      cyc(1, 1, 4, 4, MISS);
      chk("act_after_miss", 32'(active_player), 32'd1);
      chk("rd_fog_p2", 32'(rd_data), 32'(FOGGED));
      rd_set(1'b0, 0, 1);
      cyc(1, 1, 0, 0, HIT);
      chk("rd_fog_p1", 32'(rd_data), 32'(FOGGED));
      chk("p1rem_hit", 32'(p1_remaining), 32'd2);
      chk("act_after_hit", 32'(active_player), 32'd0);

      rd_set(1'b1, 4, 4);
      cyc(1, 1, 4, 4, REPEAT);
      chk("act_after_repeat", 32'(active_player), 32'd0);
      chk("rd_miss", 32'(rd_data), 32'd2);
      chk("p2rem_repeat", 32'(p2_remaining), 32'd3);

      // same-cycle read and write returns the old cell
      rd_set(1'b1, 5, 5);
      cyc(1, 1, 5, 5, HIT);
      chk("rd_prewrite", 32'(rd_data), 32'(FOGGED));
      chk("act_hit2", 32'(active_player), 32'd1);
      chk("p2rem_2", 32'(p2_remaining), 32'd2);
      cyc(1, 1, 8, 8, MISS);
      chk("rd_postwrite", 32'(rd_data), 32'd3);
      chk("act_miss2", 32'(active_player), 32'd0);
      cyc(1, 1, 5, 6, HIT);
      chk("p2rem_1", 32'(p2_remaining), 32'd1);
      cyc(1, 1, 8, 7, MISS);
      cyc(1, 1, 5, 7, WIN);
      chk("phase_over", 32'(phase), 32'd3);
      chk("winner", 32'(winner), 32'd0);
      chk("ready_over", 32'(cmd_ready), 32'd0);
      chk("act_over", 32'(active_player), 32'd0);
      chk("p2rem_0", 32'(p2_remaining), 32'd0);

      // OVER: raw reads, frozen grids, no responses
      rd_set(1'b0, 0, 1);
      cyc(0, 0, 0, 0, NONE);
      chk("rd_raw_over", 32'(rd_data), 32'd1);
      cyc(1, 1, 8, 6, NONE);
      rd_set(1'b1, 8, 6);
      cyc(0, 0, 0, 0, NONE);
      chk("rd_frozen", 32'(rd_data), 32'd0);
      chk("p1rem_frozen", 32'(p1_remaining), 32'd2);
      rd_set(1'b0, 15, 0);
      cyc(0, 0, 0, 0, NONE);
      chk("rd_oor_row", 32'(rd_data), 32'd0);
      rd_set(1'b0, 0, 9);
      cyc(0, 0, 0, 0, NONE);
      chk("rd_oor_col", 32'(rd_data), 32'd0);

      // reset on the response cycle squashes the response
      do_reset();
      cmd_valid = 1'b1;
      cmd_op    = 1'b0;
      cmd_row   = CW'(2);
      cmd_col   = CW'(2);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      reset     = 1'b1;
      #1;
      chk("rsp_squash", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("squash_p1rem", 32'(p1_remaining), 32'd0);
      chk("squash_phase", 32'(phase), 32'd0);
      cyc(0, 0, 0, 0, NONE);
      cyc(0, 0, 0, 0, NONE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
